// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider.
package div_pkg;

    localparam int WIDTH_DEF = 32;

    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_w(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_iter_addsub32.sv
// Adder/subtractor built from 8-bit carry-lookahead slices.
module div_cla8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       bigg,
    output logic       bigp
);

    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] c;
    logic       gg;
    logic       pp;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        gg   = 1'b0;
        pp   = 1'b1;
        c    = '0;
        c[0] = cin;
        // Each carry is formed from the group terms below it, not rippled.
        for (int i = 0; i < 7; i++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int j = 0; j <= i; j++) begin
                gg = g[j] | (p[j] & gg);
                pp = pp & p[j];
            end
            c[i+1] = gg | (pp & cin);
        end
        bigg = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bigg = g[i] | (p[i] & bigg);
        end
        bigp = &p;
        s    = p ^ c;
    end

endmodule

module addsub32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int NS = W / 8;

    logic [W-1:0] bx;
    logic [NS:0]  ch;
    logic [NS-1:0] gg;
    logic [NS-1:0] gp;

    assign bx = b ^ {W{sub}};

    for (genvar k = 0; k < NS; k++) begin : g_slice
        div_cla8 u_slice (
            .a    (a[8*k +: 8]),
            .b    (bx[8*k +: 8]),
            .cin  (ch[k]),
            .s    (sum[8*k +: 8]),
            .bigg (gg[k]),
            .bigp (gp[k])
        );
    end

    always_comb begin
        ch    = '0;
        ch[0] = sub;
        for (int k = 0; k < NS; k++) begin
            ch[k+1] = gg[k] | (gp[k] & ch[k]);
        end
    end

    assign cout = ch[NS];

endmodule

// File: rtl/div_iter.sv
// Multicycle signed restoring divider for the multdiv path.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    state_t           nstate;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] absb;
    logic             qsign;
    logic             rsign;
    logic             divz;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] s0;
    logic             c0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] s1;
    logic             c1;
    logic [WIDTH-1:0] absa_n;
    logic [WIDTH-1:0] absb_n;

    assign rs = {r[WIDTH-2:0], q[WIDTH-1]};

    // Both adders are shared: magnitudes at start, trial in RUN, signs at the end.
    always_comb begin
        a0 = rs;
        b0 = absb;
        a1 = '0;
        b1 = r;
        unique case (state)
            IDLE, DONE: begin
                a0 = '0;
                b0 = data_operandA;
                b1 = data_operandB;
            end
            SIGN: begin
                a0 = '0;
                b0 = q;
            end
            default: ;
        endcase
    end

    addsub32 #(.W(WIDTH)) u_trial (
        .a    (a0),
        .b    (b0),
        .sub  (1'b1),
        .sum  (s0),
        .cout (c0)
    );

    addsub32 #(.W(WIDTH)) u_neg (
        .a    (a1),
        .b    (b1),
        .sub  (1'b1),
        .sum  (s1),
        .cout (c1)
    );

    assign absa_n = data_operandA[WIDTH-1] ? s0 : data_operandA;
    assign absb_n = data_operandB[WIDTH-1] ? s1 : data_operandB;

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: if (ctrl_DIV) nstate = RUN;
            RUN:  if (cnt == CW'(WIDTH - 1)) nstate = SIGN;
            SIGN: nstate = DONE;
            DONE: nstate = ctrl_DIV ? RUN : IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            r              <= '0;
            q              <= '0;
            absb           <= '0;
            qsign          <= 1'b0;
            rsign          <= 1'b0;
            divz           <= 1'b0;
            cnt            <= '0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
        end else begin
            state <= nstate;
            unique case (state)
                IDLE, DONE: begin
                    if (ctrl_DIV) begin
                        r     <= '0;
                        q     <= absa_n;
                        absb  <= absb_n;
                        qsign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        rsign <= data_operandA[WIDTH-1];
                        // ~B + 1 carries out only when B is zero.
                        divz  <= c1;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    r   <= c0 ? s0 : rs;
                    q   <= {q[WIDTH-2:0], c0};
                    cnt <= cnt + CW'(1);
                end
                SIGN: begin
                    data_result    <= divz ? '0 : (qsign ? s0 : q);
                    data_remainder <= divz ? '0 : (rsign ? s1 : r);
                    data_exception <= divz;
                end
                default: ;
            endcase
        end
    end

    assign data_resultRDY = (state == DONE);
    assign busy           = (state == RUN) || (state == SIGN);

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter against a signed arithmetic model.
module tb_div_iter;

    localparam int W = 32;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          at;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_DIV;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] rem;
    logic        exc;
    logic        rdy;
    logic        busy;

    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    int   last_e = -1000;
    bit   mon_on = 0;
    exp_t sb[$];

    div_iter #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (a),
        .data_operandB  (b),
        .data_result    (res),
        .data_remainder (rem),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int at);
        exp_t   t;
        longint sx;
        longint sy;
        longint qq;
        longint rr;
        sx   = $signed(x);
        sy   = $signed(y);
        t.at = at;
        if (y == 32'd0) begin
            t.q = '0;
            t.r = '0;
            t.e = 1'b1;
        end else begin
            qq  = sx / sy;
            rr  = sx % sy;
            t.q = qq[31:0];
            t.r = rr[31:0];
            t.e = 1'b0;
        end
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, want, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (mon_on) begin
            check("busy", {31'b0, busy},
                  {31'b0, (cyc >= last_e) && (cyc <= last_e + W)});
            if (rdy) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rdy got=1 want=0 cyc=%0d", cyc);
                end else begin
                    exp_t t;
                    t = sb.pop_front();
                    check("latency", cyc, t.at);
                    check("result", res, t.q);
                    check("remainder", rem, t.r);
                    check("exception", {31'b0, exc}, {31'b0, t.e});
                end
            end else if (sb.size() > 0 && cyc >= sb[0].at) begin
                total++;
                bad++;
                $display("FAIL missed_rdy got=0 want=1 cyc=%0d", cyc);
                void'(sb.pop_front());
            end
        end
    end

    // Caller sits at a negedge; the following posedge is the start edge.
    task automatic start(input logic [31:0] x, input logic [31:0] y, output int e);
        a        = x;
        b        = y;
        ctrl_DIV = 1'b1;
        e        = cyc + 1;
        if (e >= last_e + W + 2) begin
            last_e = e;
            sb.push_back(model(x, y, e + W + 1));
        end
        @(negedge clock);
        ctrl_DIV = 1'b0;
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=%0d want=0", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        int e;
        int e2;
        logic [31:0] x;
        logic [31:0] y;
        reset_n  = 1'b0;
        ctrl_DIV = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(negedge clock);
        check("rst_result", res, 32'd0);
        check("rst_remainder", rem, 32'd0);
        check("rst_exception", {31'b0, exc}, 32'd0);
        check("rst_rdy", {31'b0, rdy}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset_n = 1'b1;
        mon_on  = 1;
        @(negedge clock);

        start(32'd100, 32'd7, e);
        drain();
        start(32'hFFFFFF9C, 32'd7, e);
        drain();
        start(32'd5, 32'd0, e);
        drain();
        start(32'd12, 32'd4, e);
        drain();
        start(32'h80000000, 32'hFFFFFFFF, e);
        drain();
        start(32'h80000000, 32'd1, e);
        drain();
        start(32'h7FFFFFFF, 32'h80000000, e);
        drain();

        start(32'd1000, 32'd10, e);
        wait_cyc(e + 9);
        start(32'd9, 32'd3, e2);
        wait_cyc(e + W + 1);
        start(32'd9, 32'd3, e2);
        check("b2b_edge", e2, e + W + 2);
        drain();

        start(32'd77, 32'd5, e);
        wait_cyc(e + 15);
        #2;
        reset_n = 1'b0;
        mon_on  = 0;
        #1;
        check("async_result", res, 32'd0);
        check("async_remainder", rem, 32'd0);
        check("async_exception", {31'b0, exc}, 32'd0);
        check("async_rdy", {31'b0, rdy}, 32'd0);
        check("async_busy", {31'b0, busy}, 32'd0);
        sb.delete();
        last_e = -1000;
        @(negedge clock);
        reset_n = 1'b1;
        mon_on  = 1;
        repeat (40) @(negedge clock);
        start(32'd9, 32'd3, e);
        drain();

        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            if ($urandom_range(0, 7) == 0)
                y = 32'd0;
            else if ($urandom_range(0, 2) == 0)
                y = 32'($urandom_range(0, 20)) - 32'd10;
            else
                y = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0 && last_e > 0)
                wait_cyc(last_e + W + 1);
            else
                repeat ($urandom_range(0, 40)) @(negedge clock);
            start(x, y, e);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
